// File: rtl/servo_pkg.sv
// Shared servo-link definitions: position code type, decoder state encoding,
// nominal pulse widths and the helpers used to turn microseconds into cycles.
package servo_pkg;

    typedef logic [1:0] pos_t;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2
    } dec_state_t;

    localparam int DEFAULT_CLOCK_FREQ = 12000000;

    // Nominal high times of the four position codes, shared with the transmitter.
    localparam int POS0_US = 500;
    localparam int POS1_US = 1000;
    localparam int POS2_US = 1500;
    localparam int POS3_US = 2000;

    localparam int HI_CNT_W  = 15;
    localparam int PER_CNT_W = 19;

    function automatic int cycPerUs(input int clockFreq);
        return clockFreq / 1000000;
    endfunction

    localparam int CYC_US = cycPerUs(DEFAULT_CLOCK_FREQ);

    // Decision thresholds sit halfway between neighbouring nominal widths.
    function automatic int midpointUs(input int aUs, input int bUs);
        return (aUs + bUs) / 2;
    endfunction

endpackage

// File: rtl/servo_pwm_decoder_sync_2ff.sv
// Two-flop synchroniser that brings the asynchronous PWM pin into the clock domain.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double register the input; both stages clear to 0 on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures each high pulse, decodes it to a 2-bit position,
// flags malformed pulses and drops signal_ok when the pulse train goes quiet.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CLOCK_FREQ   = DEFAULT_CLOCK_FREQ,
    parameter int MIN_PULSE_US = 250,
    parameter int MAX_PULSE_US = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pwm_in,
    output logic [1:0] o_position,
    output logic       o_pos_valid,
    output logic       o_pulse_err,
    output logic       o_signal_ok
);

    localparam int CYC = cycPerUs(CLOCK_FREQ);

    localparam logic [HI_CNT_W-1:0]  MIN_CYC     = HI_CNT_W'(MIN_PULSE_US * CYC);
    localparam logic [HI_CNT_W-1:0]  MAX_CYC     = HI_CNT_W'(MAX_PULSE_US * CYC);
    localparam logic [HI_CNT_W-1:0]  TH_01       = HI_CNT_W'(midpointUs(POS0_US, POS1_US) * CYC);
    localparam logic [HI_CNT_W-1:0]  TH_12       = HI_CNT_W'(midpointUs(POS1_US, POS2_US) * CYC);
    localparam logic [HI_CNT_W-1:0]  TH_23       = HI_CNT_W'(midpointUs(POS2_US, POS3_US) * CYC);
    localparam logic [PER_CNT_W-1:0] TIMEOUT_CYC = PER_CNT_W'(TIMEOUT_US * CYC);

    logic                 w_pwm_s;
    logic                 r_pwm_d;
    logic                 w_rise;
    logic                 w_fall;
    logic                 r_rise;
    logic                 r_fall;
    logic [1:0]           r_fill;
    logic [HI_CNT_W-1:0]  r_hi_cnt;
    logic [PER_CNT_W-1:0] r_per_cnt;
    logic                 w_timeout_hit;

    dec_state_t r_state;
    dec_state_t w_state_next;

    pos_t r_position;
    logic r_pos_valid;
    logic r_pulse_err;
    logic r_signal_ok;
    pos_t w_pos_next;
    logic w_valid_next;
    logic w_err_next;
    logic w_ok_next;

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_pwm_in),
        .o_q   (w_pwm_s)
    );

    assign w_rise = w_pwm_s & ~r_pwm_d;
    assign w_fall = ~w_pwm_s & r_pwm_d;

    // Delay the synchronised level and register the edges so the FSM sees a clean strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm_d <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_pwm_d <= w_pwm_s;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
        end
    end

    // Count cycles since reset until the synchroniser carries the real pin level;
    // until then its reset zeros would look like a low and let a partial pulse through.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fill <= 2'd0;
        end else if (r_fill != 2'd3) begin
            r_fill <= r_fill + 2'd1;
        end
    end

    // High-time counter: starts at 1 on the rising edge, holds its value while low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi_cnt <= '0;
        end else if (w_rise) begin
            r_hi_cnt <= HI_CNT_W'(1);
        end else if (w_pwm_s && (r_hi_cnt != '1)) begin
            r_hi_cnt <= r_hi_cnt + HI_CNT_W'(1);
        end
    end

    // Rise-to-rise period counter, saturating at the loss-of-signal limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_per_cnt <= '0;
        end else if (w_rise) begin
            r_per_cnt <= '0;
        end else if (r_per_cnt != TIMEOUT_CYC) begin
            r_per_cnt <= r_per_cnt + PER_CNT_W'(1);
        end
    end

    assign w_timeout_hit = !w_rise && (r_per_cnt == (TIMEOUT_CYC - PER_CNT_W'(1)));

    function automatic pos_t classifyWidth(input logic [HI_CNT_W-1:0] width);
        if (width < TH_01) begin
            return 2'd0;
        end else if (width < TH_12) begin
            return 2'd1;
        end else if (width < TH_23) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    // Decoder state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next outputs; a fall classified in the same cycle as the
    // timeout overrides it because its assignment to w_ok_next comes later.
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_position;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_ok_next    = r_signal_ok;

        if (w_timeout_hit) begin
            w_ok_next = 1'b0;
        end

        case (r_state)
            WAIT_LOW: begin
                if ((r_fill == 2'd3) && !w_pwm_s) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (r_rise) begin
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (r_fall) begin
                    w_state_next = IDLE;
                    if (r_hi_cnt < MIN_CYC) begin
                        w_err_next = 1'b1;
                        w_ok_next  = 1'b0;
                    end else begin
                        w_valid_next = 1'b1;
                        w_ok_next    = 1'b1;
                        w_pos_next   = classifyWidth(r_hi_cnt);
                    end
                end else if (r_hi_cnt >= MAX_CYC) begin
                    w_err_next   = 1'b1;
                    w_ok_next    = 1'b0;
                    w_state_next = WAIT_LOW;
                end
            end
            default: begin
                w_state_next = WAIT_LOW;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_position  <= 2'd0;
            r_pos_valid <= 1'b0;
            r_pulse_err <= 1'b0;
            r_signal_ok <= 1'b0;
        end else begin
            r_position  <= w_pos_next;
            r_pos_valid <= w_valid_next;
            r_pulse_err <= w_err_next;
            r_signal_ok <= w_ok_next;
        end
    end

    assign o_position  = r_position;
    assign o_pos_valid = r_pos_valid;
    assign o_pulse_err = r_pulse_err;
    assign o_signal_ok = r_signal_ok;

endmodule
